// File: rtl/exibidor_sequencia_pkg.sv
// exibidor_sequencia shared constants
// state codes and default timing
package exibidor_sequencia_pkg;

  localparam int T_LIGADO_PAD   = 500;
  localparam int T_APAGADO_PAD  = 250;
  localparam int LARG_TEMPO_PAD = 10;
  localparam int LARG_END       = 4;

  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    ESPERA   = 4'h1,
    REGISTRA = 4'h2,
    ACENDE   = 4'h3,
    APAGA    = 4'h4,
    PROXIMO  = 4'h5,
    FIM      = 4'hF
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// contador_m: interval counter
// sync clear, enable, terminal compare
module contador_m #(
  parameter int N = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [N-1:0] limite,
  output logic         fim
);

  logic [N-1:0] q;

  // count up while enabled; clear wins
  always_ff @(posedge clock) begin
    if (!reset)
      q <= '0;
    else if (zera)
      q <= '0;
    else if (conta)
      q <= q + 1'b1;
  end

  assign fim = (q == limite);

endmodule

// File: rtl/exibidor_sequencia.sv
// exibidor_sequencia: plays the stored
// sequence on the leds for one round
module exibidor_sequencia
  import exibidor_sequencia_pkg::*;
#(
  parameter int T_LIGADO   = T_LIGADO_PAD,
  parameter int T_APAGADO  = T_APAGADO_PAD,
  parameter int LARG_TEMPO = LARG_TEMPO_PAD
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [LARG_END-1:0] rodada,
  input  logic [3:0]          dado_memoria,
  output logic [LARG_END-1:0] endereco,
  output logic [3:0]          leds,
  output logic                exibindo,
  output logic                pronto,
  output logic [3:0]          db_estado
);

  estado_t estado, prox;

  logic [LARG_END-1:0]   rodada_reg;
  logic [LARG_TEMPO-1:0] limite;
  logic zera, conta, fimT;
  logic carrega, zera_end, inc_end;
  logic grava_leds, apaga_leds;

  // the same counter times both phases
  assign limite = (estado == ACENDE)
                ? LARG_TEMPO'(T_LIGADO - 1)
                : LARG_TEMPO'(T_APAGADO - 1);

  contador_m #(.N(LARG_TEMPO)) u_tempo (
    .clock  (clock),
    .reset  (reset),
    .zera   (zera),
    .conta  (conta),
    .limite (limite),
    .fim    (fimT)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!reset)
      estado <= INICIAL;
    else
      estado <= prox;
  end

  // next state and datapath strobes
  always_comb begin
    prox       = estado;
    zera       = 1'b0;
    conta      = 1'b0;
    carrega    = 1'b0;
    zera_end   = 1'b0;
    inc_end    = 1'b0;
    grava_leds = 1'b0;
    apaga_leds = 1'b0;
    unique case (estado)
      INICIAL:
        if (iniciar) begin
          carrega  = 1'b1;
          zera_end = 1'b1;
          prox     = ESPERA;
        end
      ESPERA:
        prox = REGISTRA;
      REGISTRA: begin
        grava_leds = 1'b1;
        zera       = 1'b1;
        prox       = ACENDE;
      end
      ACENDE:
        if (fimT) begin
          apaga_leds = 1'b1;
          zera       = 1'b1;
          prox       = APAGA;
        end else begin
          conta = 1'b1;
        end
      APAGA:
        if (fimT) begin
          zera = 1'b1;
          prox = (endereco == rodada_reg)
               ? FIM : PROXIMO;
        end else begin
          conta = 1'b1;
        end
      PROXIMO: begin
        inc_end = 1'b1;
        prox    = ESPERA;
      end
      FIM:
        prox = INICIAL;
      default:
        prox = INICIAL;
    endcase
  end

  // address, round latch and led registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      endereco   <= '0;
      leds       <= '0;
      rodada_reg <= '0;
    end else begin
      if (carrega)
        rodada_reg <= rodada;
      if (zera_end)
        endereco <= '0;
      else if (inc_end)
        endereco <= endereco + 1'b1;
      if (grava_leds)
        leds <= dado_memoria;
      else if (apaga_leds)
        leds <= '0;
    end
  end

  assign exibindo  = (estado != INICIAL) &&
                     (estado != FIM);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// tb_exibidor_sequencia: scoreboard bench
// expected per-cycle outputs queued at start
module tb_exibidor_sequencia;

  localparam int TL = 3;
  localparam int TA = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] rodada = 4'h0;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic [3:0] db_estado;
  logic       exibindo;
  logic       pronto;

  logic [3:0]  mem [16];
  logic [15:0] fila [$];
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock)
    dado_memoria <= mem[endereco];

  exibidor_sequencia #(
    .T_LIGADO   (TL),
    .T_APAGADO  (TA),
    .LARG_TEMPO (10)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .rodada       (rodada),
    .dado_memoria (dado_memoria),
    .endereco     (endereco),
    .leds         (leds),
    .exibindo     (exibindo),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  function automatic logic [15:0] mk(
    input logic [3:0] st, lv, ev,
    input logic ex, pr);
    return {st, lv, ev, ex, pr, 2'b00};
  endfunction

  function automatic logic [15:0] obs_v();
    return {db_estado, leds, endereco,
            exibindo, pronto, 2'b00};
  endfunction

  task automatic verifica(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (st,leds,end,exib,pronto)",
               tag, obs, exp);
    end
  endtask

  task automatic push_idle(input int n,
                           input logic [3:0] ev);
    for (int k = 0; k < n; k++)
      fila.push_back(mk(4'h0, 4'h0, ev, 1'b0, 1'b0));
  endtask

  task automatic push_play(input int r);
    for (int i = 0; i <= r; i++) begin
      fila.push_back(mk(4'h1, 4'h0, 4'(i), 1'b1, 1'b0));
      fila.push_back(mk(4'h2, 4'h0, 4'(i), 1'b1, 1'b0));
      for (int t = 0; t < TL; t++)
        fila.push_back(mk(4'h3, mem[i], 4'(i), 1'b1, 1'b0));
      for (int t = 0; t < TA; t++)
        fila.push_back(mk(4'h4, 4'h0, 4'(i), 1'b1, 1'b0));
      if (i < r)
        fila.push_back(mk(4'h5, 4'h0, 4'(i), 1'b1, 1'b0));
    end
    fila.push_back(mk(4'hF, 4'h0, 4'(r), 1'b0, 1'b1));
    fila.push_back(mk(4'h0, 4'h0, 4'(r), 1'b0, 1'b0));
  endtask

  task automatic inicia(input logic [3:0] r);
    @(negedge clock);
    rodada  = r;
    iniciar = 1'b1;
  endtask

  task automatic roda(
    input string tag,
    input int n_max,
    input bit hold,
    input int chg_at,
    input logic [3:0] chg_val);
    int idx = 0;
    while (fila.size() > 0 &&
           (n_max < 0 || idx < n_max)) begin
      @(negedge clock);
      if (idx == 0 && !hold)
        iniciar = 1'b0;
      if (idx == chg_at)
        rodada = chg_val;
      verifica($sformatf("%s[%0d]", tag, idx),
               obs_v(), fila.pop_front());
      idx++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      mem[i] = 4'hA;
    mem[0] = 4'h1;
    mem[1] = 4'h2;
    mem[2] = 4'h4;
    mem[3] = 4'h8;
    mem[4] = 4'h0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    verifica("reset", obs_v(),
             mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    reset = 1'b1;
    push_idle(10, 4'h0);
    roda("idle", -1, 1'b0, -1, 4'h0);

    inicia(4'd0);
    push_play(0);
    roda("r0", -1, 1'b0, -1, 4'h0);

    inicia(4'd3);
    push_play(3);
    roda("r3", -1, 1'b0, 10, 4'h0);

    inicia(4'd4);
    push_play(4);
    push_play(0);
    roda("r4hold", -1, 1'b1, 5, 4'h0);
    iniciar = 1'b0;
    push_idle(3, 4'h0);
    roda("r4idle", -1, 1'b0, -1, 4'h0);

    inicia(4'd3);
    push_play(3);
    roda("pre_rst", 19, 1'b0, -1, 4'h0);
    fila.delete();
    reset = 1'b0;
    @(negedge clock);
    verifica("mid_rst", obs_v(),
             mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    reset = 1'b1;
    push_idle(4, 4'h0);
    roda("post_rst", -1, 1'b0, -1, 4'h0);

    for (int i = 0; i < 16; i++)
      mem[i] = 4'(i);
    inicia(4'd15);
    push_play(15);
    roda("r15", -1, 1'b0, -1, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
